// File: rtl/morse_capture_stream_if.sv
// Output stream of the Morse capture stage: one entry per character or word gap,
// presented first-word-fall-through with a valid/ready handshake.
interface morse_capture_stream_if #(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = 3
);
  logic               out_valid;
  logic               out_ready;
  logic [LEN_W-1:0]   out_len;
  logic [MAX_LEN-1:0] out_dits_dahs;
  logic               out_error;
  logic               out_word_end;

  modport master (
    output out_valid, out_len, out_dits_dahs, out_error, out_word_end,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_len, out_dits_dahs, out_error, out_word_end,
    output out_ready
  );
endinterface

// File: rtl/morse_capture_stream.sv
// Morse capture: times marks/spaces in ce ticks, classifies dits/dahs, assembles
// characters and word-gap markers into a small FWFT FIFO.
module morse_capture_stream #(
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = 3,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clear,
  input  logic             signal,
  input  logic [CNT_W-1:0] dit_time,
  input  logic [CNT_W-1:0] dah_time,
  input  logic [CNT_W-1:0] char_time,
  input  logic [CNT_W-1:0] word_time,
  input  logic [CNT_W-1:0] tol_time,
  output logic             overflow,
  output logic             busy,
  morse_capture_stream_if.master stream
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = LEN_W + MAX_LEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_GAP} state_e;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W:0] sat_sub(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a > b) ? ({1'b0, a} - {1'b0, b}) : '0;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] dd_q, dd_d;
  logic               err_q, err_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]     fcnt_q, fcnt_d;
  logic               ovf_q, ovf_d;

  logic [CNT_W:0]     char_raw, char_thr, word_raw, word_thr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               is_dit, is_dah;
  logic               push, push_acc, pop;
  logic [ENT_W-1:0]   push_ent;

  // Thresholds are widened by one bit so char_thr+1 and the compares never wrap.
  always_comb begin
    char_raw = sat_sub(char_time, tol_time);
    char_thr = (char_raw < (CNT_W+1)'(2)) ? (CNT_W+1)'(2) : char_raw;
    word_raw = sat_sub(word_time, tol_time);
    word_thr = (word_raw > char_thr) ? word_raw : char_thr + (CNT_W+1)'(1);
  end

  assign cnt_inc = sat_inc(cnt_q);
  assign is_dit  = abs_diff(cnt_q, dit_time) <= {1'b0, tol_time};
  assign is_dah  = !is_dit && (abs_diff(cnt_q, dah_time) <= {1'b0, tol_time});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    dd_d     = dd_q;
    err_d    = err_q;
    push     = 1'b0;
    push_ent = '0;
    if (ce) begin
      case (state_q)
        S_IDLE: if (signal) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
          len_d   = '0;
          dd_d    = '0;
          err_d   = 1'b0;
        end
        S_MARK: if (signal) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = S_SPACE;
          cnt_d   = CNT_W'(1);
          if (len_q < LEN_W'(MAX_LEN)) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (len_q == LEN_W'(i)) dd_d[i] = is_dah;
            len_d = len_q + LEN_W'(1);
            err_d = err_q | (!is_dit && !is_dah);
          end else begin
            err_d = 1'b1;
          end
        end
        S_SPACE: if (signal) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if ({1'b0, cnt_inc} == char_thr) begin
            push     = 1'b1;
            push_ent = {len_q, dd_q, err_q, 1'b0};
            state_d  = S_GAP;
          end
        end
        S_GAP: if (signal) begin
          state_d = S_MARK;
          cnt_d   = CNT_W'(1);
          len_d   = '0;
          dd_d    = '0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if ({1'b0, cnt_inc} == word_thr) begin
            push     = 1'b1;
            push_ent = {LEN_W'(0), MAX_LEN'(0), 1'b0, 1'b1};
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (clear) begin
      state_d = S_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      dd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dd_q    <= dd_d;
      err_q   <= err_d;
    end
  end

  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign pop      = stream.out_valid && stream.out_ready;
  assign push_acc = push && ((fcnt_q < (PTR_W+1)'(DEPTH)) || pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      wr_d   = '0;
      rd_d   = '0;
      fcnt_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push_acc) wr_d = wr_q + PTR_W'(1);
      if (pop)      rd_d = rd_q + PTR_W'(1);
      if (push && !push_acc) ovf_d = 1'b1;
      case ({push_acc, pop})
        2'b10:   fcnt_d = fcnt_q + (PTR_W+1)'(1);
        2'b01:   fcnt_d = fcnt_q - (PTR_W+1)'(1);
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_acc && !clear) mem_q[wr_q] <= push_ent;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign stream.out_valid     = (fcnt_q != '0);
  assign stream.out_len       = mem_q[rd_q][ENT_W-1 -: LEN_W];
  assign stream.out_dits_dahs = mem_q[rd_q][MAX_LEN+1:2];
  assign stream.out_error     = mem_q[rd_q][1];
  assign stream.out_word_end  = mem_q[rd_q][0];
  assign overflow             = ovf_q;
  assign busy                 = (state_q != S_IDLE);

endmodule
